// File: rtl/data_mem_bytelane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_mem_bytelane
//  Description : MEM-stage data memory with byte-lane stores, extended
//                sub-word loads, alignment/range flags and post-reset clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bytelane #(
  parameter int DEPTH        = 1024,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        rd_valid,
  output logic        busy,
  output logic        misalign_err,
  output logic        range_err
);

  localparam int                  c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w-1:0] c_last   = c_addr_w'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_addr_w-1:0] r_clr_idx;
  logic [31:0]         r_mem [DEPTH];

  logic                w_acc;
  logic                w_mis;
  logic                w_rng;
  logic                w_ok;
  logic                w_wr;
  logic [c_addr_w-1:0] w_idx;
  logic [3:0]          w_be;
  logic [31:0]         w_wdat;
  logic [31:0]         w_rword;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_ld;

  logic [RD_LAT-1:0]   r_vld;
  logic [RD_LAT-1:0]   r_mis;
  logic [RD_LAT-1:0]   r_rng;
  logic [31:0]         r_data [RD_LAT];

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) r_state <= ST_INIT;
      else                   r_state <= ST_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_idx <= r_clr_idx + c_addr_w'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_clr_idx == c_last) w_state_nxt = ST_IDLE;
  end

  assign busy = (r_state == ST_INIT);

  // ---------------- request decode ----------------
  assign w_acc = ce & ~busy & ~rst;
  assign w_idx = addr[c_addr_w+1:2];
  assign w_rng = |addr[31:c_addr_w+2];
  assign w_mis = ((size == 2'b01) & addr[0]) | (size[1] & (|addr[1:0]));
  assign w_ok  = ~w_mis & ~w_rng;
  assign w_wr  = w_acc & we & w_ok;

  // Sub-word store data is replicated so every lane carries it; w_be picks.
  always_comb begin
    w_be   = 4'b1111;
    w_wdat = wtData;
    case (size)
      2'b00: begin
        w_be   = 4'b0001 << addr[1:0];
        w_wdat = {4{wtData[7:0]}};
      end
      2'b01: begin
        w_be   = addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{wtData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  // ---------------- load extraction ----------------
  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{addr[1:0], 3'b000} +: 8];
  assign w_half  = w_rword[{addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ld = w_rword;
    case (size)
      2'b00:   w_ld = {{24{sign_ext & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{sign_ext & w_half[15]}}, w_half};
      default: ;
    endcase
    if (!w_ok) w_ld = '0;
  end

  // ---------------- read / flag pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_mis <= '0;
      r_rng <= '0;
      for (int s = 0; s < RD_LAT; s++) r_data[s] <= '0;
    end else begin
      r_vld[0]  <= w_acc & ~we;
      r_mis[0]  <= w_acc & w_mis;
      r_rng[0]  <= w_acc & w_rng;
      r_data[0] <= (w_acc & ~we) ? w_ld : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_mis[s]  <= r_mis[s-1];
        r_rng[s]  <= r_rng[s-1];
        r_data[s] <= r_data[s-1];
      end
    end
  end

  assign rd_valid     = r_vld[RD_LAT-1];
  assign misalign_err = r_mis[RD_LAT-1];
  assign range_err    = r_rng[RD_LAT-1];
  assign rdData       = r_vld[RD_LAT-1] ? r_data[RD_LAT-1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bytelane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_bytelane
//  Description : Scoreboard bench for data_mem_bytelane against a byte-array
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_bytelane;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wtData = '0;
  logic [31:0] rdData;
  logic        rd_valid;
  logic        busy;
  logic        misalign_err;
  logic        range_err;

  data_mem_bytelane #(
    .DEPTH(DEPTH), .RD_LAT(RD_LAT), .CLEAR_ON_RST(1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wtData(wtData),
    .rdData(rdData), .rd_valid(rd_valid), .busy(busy),
    .misalign_err(misalign_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        vld;
    logic [31:0] data;
    logic        mis;
    logic        rng;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl [DEPTH*4];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;

  // Monitor: every response the DUT presents is matched against the queue.
  always @(posedge clk) begin : mon
    exp_t e;
    cyc++;
    #1;
    if (mon_en) begin
      if (rd_valid || misalign_err || range_err) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output cyc=%0d vld=%0b data=%h mis=%0b rng=%0b required none",
                   cyc, rd_valid, rdData, misalign_err, range_err);
        end else begin
          e = sbq.pop_front();
          if (e.due != cyc || rd_valid !== e.vld || rdData !== e.data ||
              misalign_err !== e.mis || range_err !== e.rng) begin
            bad++;
            $display("FAIL response cyc=%0d got vld=%0b data=%h mis=%0b rng=%0b required due=%0d vld=%0b data=%h mis=%0b rng=%0b",
                     cyc, rd_valid, rdData, misalign_err, range_err,
                     e.due, e.vld, e.data, e.mis, e.rng);
          end
        end
      end else begin
        if (sbq.size() != 0 && sbq[0].due <= cyc) begin
          total++;
          bad++;
          e = sbq.pop_front();
          $display("FAIL missing_output cyc=%0d got none required data=%h due=%0d", cyc, e.data, e.due);
        end
        total++;
        if (rdData !== 32'h0) begin
          bad++;
          $display("FAIL idle_rddata cyc=%0d got %h required 00000000", cyc, rdData);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  // Reference model: memory as a flat little-endian byte array.
  task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    int          n;
    logic        mis;
    logic        rng;
    logic [31:0] val;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
    rng = (a >= DEPTH * 4);
    val = '0;
    if (w) begin
      if (!mis && !rng)
        for (int i = 0; i < n; i++) mdl[a + i] = d[8*i +: 8];
      else
        sbq.push_back('{cyc + RD_LAT, 1'b0, 32'h0, mis, rng});
    end else begin
      if (!mis && !rng) begin
        for (int i = 0; i < n; i++) val = val | (32'(mdl[a + i]) << (8 * i));
        if (sx && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
      end
      sbq.push_back('{cyc + RD_LAT, 1'b1, val, mis, rng});
    end
  endtask

  task automatic req(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wtData = d;
    if (!busy && !rst) model(w, sz, sx, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = 1'b0; we = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    idle(1);
    while (sbq.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ce = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_rddata", rdData, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    check("rst_range", {31'h0, range_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
  endtask

  // Counts busy cycles; optionally pokes requests that must be ignored.
  task automatic count_busy(input string name, input bit poke);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      if (poke && n > 50) begin
        ce = 1'b1; we = n[0]; size = 2'b10; sign_ext = 1'b0;
        addr = n[1] ? 32'h40 : 32'h41; wtData = 32'hCAFE_F00D;
      end
      @(negedge clk);
    end
    ce = 1'b0; we = 1'b0;
    check(name, n, DEPTH);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH * 4; i++) mdl[i] = 8'h0;

    do_reset();
    count_busy("busy_len_first", 1'b0);

    // Restart the clear midway; pokes during busy must not land or flag.
    do_reset();
    for (int i = 0; i < 500; i++) req(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678);
    do_reset();
    count_busy("busy_len_restart", 1'b1);

    req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    drain();

    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);

    req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001);
    req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    req(1'b0, 2'b01, 1'b1, 32'h21, 32'h0);

    req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D);
    req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF);
    req(1'b1, 2'b10, 1'b0, 32'h1001, 32'hDEAD_BEEF);
    idle(2);
    req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drain();

    for (int i = 0; i < 4; i++) req(1'b0, 2'b10, 1'b0, 32'h10 + 32'(4 * i), 32'h0);
    drain();

    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0)
        idle(1);
      else
        req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, a, $urandom);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
